garnet_ddr_axi_tester: RTL and testbench
========================================

Name: garnet_ddr_axi_tester

Overview:
- AXI4 initiator that drives one DDR controller's 512-bit AXI slave port: writes a seeded address-derived pattern over a region, reads it back, and checks every beat.
- Used for bring-up and soak testing of each DDR channel. Sits beside the dual-DDR wrapper in place of, or muxed with, the system interconnect master.

Parameters:
BURST_LEN, 16, beats per burst; power of two, 1..64, so a burst never crosses 4 KiB.
AXI_ID, 0, 6-bit ID driven on AW/AR and expected on B/R.

Ports:
clk  input  1  sole clock (AXI and control)
resetn  input  1  reset, asynchronous, active-low
init_calib_complete  input  1  DDR calibration done; gates test start
start  input  1  single-cycle start pulse; ignored while busy
base_addr  input  64  region base; must be aligned to BURST_LEN*64 bytes
num_bursts  input  16  bursts to write, then read
seed  input  64  pattern seed, sampled on start
busy  output  1  test in progress
done  output  1  sticky completion flag; cleared by next accepted start
pass  output  1  done and err_count==0
err_count  output  32  errored beats/responses, saturating
first_err_addr  output  64  byte address of first errored beat or burst
M_AXI_awvalid/awready/awaddr/awlen/awid  out/in/out/out/out  1/1/64/8/6  write address
M_AXI_aw{burst,size,cache,lock,prot,qos,region}  output  2/3/4/1/3/4/4  constants: INCR, 6, 4'b0011, 0, 0, 0, 0
M_AXI_wvalid/wready/wdata/wstrb/wlast  out/in/out/out/out  1/1/512/64/1  write data; wstrb all ones
M_AXI_bvalid/bready/bid/bresp  in/out/in/in  1/1/6/2  write response
M_AXI_arvalid/arready/araddr/arlen/arid  out/in/out/out/out  1/1/64/8/6  read address
M_AXI_ar{burst,size,cache,lock,prot,qos,region}  output  as AW  same constants
M_AXI_rvalid/rready/rdata/rid/rresp/rlast  in/out/in/in/in/in  1/1/512/6/2/1  read data

Behaviour:
- Reset (async, immediate): all valid/ready low; busy=0, done=0, pass=0, err_count=0, first_err_addr=0; FSM=IDLE. Reset mid-burst abandons the transaction; no completion is required.
- Pattern: for a beat at byte address A (64-byte aligned), 64-bit lane k (k=0..7) = (A + 8k) XOR seed.
- FSM states: IDLE, WAIT_CAL, WR, WR_RESP, RD, FIN.
- IDLE: on start, latch base_addr, num_bursts and seed; clear err_count, first_err_addr and done; busy=1; go to WAIT_CAL.
- WAIT_CAL: wait for init_calib_complete=1. If num_bursts==0, go to FIN. Otherwise go to WR. After leaving WAIT_CAL, a drop of init_calib_complete is ignored.
- WR: awvalid and wvalid asserted together at burst start.
  - AW and W complete independently; each valid drops after its own handshake and is never withdrawn before it.
  - awaddr = base + burst_idx*BURST_LEN*64; awlen = BURST_LEN-1.
  - W beats are consecutive; wlast on beat BURST_LEN-1.
  - When both AW and the last W beat have handshaken, go to WR_RESP.
- WR_RESP: bready=1. On bvalid: if bresp!=OKAY or bid!=AXI_ID, count one error at the burst address. Then go to the next burst (WR), or to RD with burst_idx=0 after the last burst.
- RD: one outstanding burst. arvalid is held until arready.
  - rready=1 from the AR handshake until the last beat is received.
  - Each received beat is checked against its expected data, rid, rresp==OKAY, and rlast==(beat==BURST_LEN-1). Any failure counts as one error for that beat.
  - Beat BURST_LEN-1 ends the burst regardless of rlast. After the last burst, go to FIN.
- FIN: busy=0, done=1, pass=(err_count==0); go to IDLE.
- err_count saturates at 0xFFFF_FFFF. first_err_addr is written only on the 0->1 transition of err_count.
- Address arithmetic is 64-bit and wraps modulo 2^64; no error is raised on wrap.
- All outputs are registered. Idle bus: valids low, bready/rready low.

Test Plan:
- BURST_LEN=16, base=0x1000, num_bursts=4, seed=0, ideal slave (ready=1) -> 4 AW at 0x1000/0x1400/0x1800/0x1C00 with awlen=15; 64 W beats; beat 0 lane 1 = 0x1008. Then 4 AR and 64 R beats; done=1, pass=1, err_count=0.
- Slave corrupts rdata lane 0 of beat 5 in burst 2 (seed=0xA5A5...) -> err_count=1, first_err_addr=0x1000+2*1024+5*64=0x1940, pass=0.
- Slave returns bresp=SLVERR on burst 1 and a wrong rid on one beat -> err_count=2; first_err_addr=0x1400.
- init_calib_complete held 0 for 100 cycles after start, random awready/wready/arready/rvalid stalls with W leading AW -> no AW/AR/W traffic before calib; then pass=1 with all valids stable while stalled.
- num_bursts=0 -> done=1, pass=1 immediately after calibration, no AXI traffic. A start during busy is ignored.
- resetn low mid-W-burst -> valids low in the same cycle; after release busy=0, done=0; a new start completes with pass=1.

Source files
------------

// File: rtl/garnet_ddr_axi_tester.sv
// AXI4 memory tester for one DDR channel: writes an address-derived pattern over a
// region in BURST_LEN-beat bursts, reads it back, and counts every bad beat or response.
module garnet_ddr_axi_tester #(
    parameter int          BURST_LEN = 16,
    parameter logic [5:0]  AXI_ID    = 6'd0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          init_calib_complete,
    input  logic          start,
    input  logic [63:0]   base_addr,
    input  logic [15:0]   num_bursts,
    input  logic [63:0]   seed,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   err_count,
    output logic [63:0]   first_err_addr,
    output logic [2:0]    dbg_state,
    output logic          M_AXI_awvalid,
    input  logic          M_AXI_awready,
    output logic [63:0]   M_AXI_awaddr,
    output logic [7:0]    M_AXI_awlen,
    output logic [5:0]    M_AXI_awid,
    output logic [1:0]    M_AXI_awburst,
    output logic [2:0]    M_AXI_awsize,
    output logic [3:0]    M_AXI_awcache,
    output logic          M_AXI_awlock,
    output logic [2:0]    M_AXI_awprot,
    output logic [3:0]    M_AXI_awqos,
    output logic [3:0]    M_AXI_awregion,
    output logic          M_AXI_wvalid,
    input  logic          M_AXI_wready,
    output logic [511:0]  M_AXI_wdata,
    output logic [63:0]   M_AXI_wstrb,
    output logic          M_AXI_wlast,
    input  logic          M_AXI_bvalid,
    output logic          M_AXI_bready,
    input  logic [5:0]    M_AXI_bid,
    input  logic [1:0]    M_AXI_bresp,
    output logic          M_AXI_arvalid,
    input  logic          M_AXI_arready,
    output logic [63:0]   M_AXI_araddr,
    output logic [7:0]    M_AXI_arlen,
    output logic [5:0]    M_AXI_arid,
    output logic [1:0]    M_AXI_arburst,
    output logic [2:0]    M_AXI_arsize,
    output logic [3:0]    M_AXI_arcache,
    output logic          M_AXI_arlock,
    output logic [2:0]    M_AXI_arprot,
    output logic [3:0]    M_AXI_arqos,
    output logic [3:0]    M_AXI_arregion,
    input  logic          M_AXI_rvalid,
    output logic          M_AXI_rready,
    input  logic [511:0]  M_AXI_rdata,
    input  logic [5:0]    M_AXI_rid,
    input  logic [1:0]    M_AXI_rresp,
    input  logic          M_AXI_rlast
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // a valid, once raised, holds its payload until that edge.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CAL = 3'd1,
        S_WR       = 3'd2,
        S_WR_RESP  = 3'd3,
        S_RD       = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    localparam logic [6:0]  LAST_BEAT   = 7'(BURST_LEN - 1);
    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN * 64);

    state_t         r_state;
    logic [63:0]    r_base, r_seed, r_burst_addr;
    logic [15:0]    r_num, r_burst_idx;
    logic [6:0]     r_beat;
    logic           r_aw_done, r_w_done;
    logic           r_busy, r_done, r_pass;
    logic [31:0]    r_err_count;
    logic [63:0]    r_first_err_addr;
    logic           r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
    logic [63:0]    r_awaddr, r_araddr;
    logic [511:0]   r_wdata;

    logic [63:0]    w_beat_addr, w_next_addr, w_err_addr;
    logic [511:0]   w_exp_rdata;
    logic           w_b_err, w_r_err, w_err_hit, w_aw_fin, w_w_fin, w_last_burst;

    function automatic logic [511:0] f_pattern(input logic [63:0] a, input logic [63:0] s);
        logic [511:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p[k*64 +: 64] = (a + 64'(8 * k)) ^ s;
        return p;
    endfunction

    always_comb begin
        w_beat_addr  = r_burst_addr + {51'd0, r_beat, 6'd0};
        w_next_addr  = r_burst_addr + BURST_BYTES;
        w_exp_rdata  = f_pattern(w_beat_addr, r_seed);
        w_b_err      = (r_state == S_WR_RESP) && M_AXI_bvalid && r_bready &&
                       ((M_AXI_bresp != 2'b00) || (M_AXI_bid != AXI_ID));
        w_r_err      = (r_state == S_RD) && M_AXI_rvalid && r_rready &&
                       ((M_AXI_rdata != w_exp_rdata) || (M_AXI_rid != AXI_ID) ||
                        (M_AXI_rresp != 2'b00) || (M_AXI_rlast != (r_beat == LAST_BEAT)));
        w_err_hit    = w_b_err || w_r_err;
        w_err_addr   = w_b_err ? r_burst_addr : w_beat_addr;
        w_aw_fin     = r_aw_done || (r_awvalid && M_AXI_awready);
        w_w_fin      = r_w_done || (r_wvalid && M_AXI_wready && r_wlast);
        w_last_burst = (r_burst_idx + 16'd1 == r_num);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_base           <= '0;
            r_seed           <= '0;
            r_num            <= '0;
            r_burst_idx      <= '0;
            r_burst_addr     <= '0;
            r_beat           <= '0;
            r_aw_done        <= 1'b0;
            r_w_done         <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_awvalid        <= 1'b0;
            r_awaddr         <= '0;
            r_wvalid         <= 1'b0;
            r_wdata          <= '0;
            r_wlast          <= 1'b0;
            r_bready         <= 1'b0;
            r_arvalid        <= 1'b0;
            r_araddr         <= '0;
            r_rready         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_num   <= num_bursts;
                        r_seed  <= seed;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_CAL;
                    end
                end
                S_WAIT_CAL: begin
                    if (init_calib_complete) begin
                        r_burst_idx  <= '0;
                        r_burst_addr <= r_base;
                        if (r_num == 16'd0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state   <= S_WR;
                            r_awvalid <= 1'b1;
                            r_awaddr  <= r_base;
                            r_wvalid  <= 1'b1;
                            r_wdata   <= f_pattern(r_base, r_seed);
                            r_wlast   <= (LAST_BEAT == 7'd0);
                            r_beat    <= '0;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (r_awvalid && M_AXI_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && M_AXI_wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_w_done <= 1'b1;
                        end else begin
                            r_beat  <= r_beat + 7'd1;
                            r_wdata <= f_pattern(w_beat_addr + 64'd64, r_seed);
                            r_wlast <= (r_beat + 7'd1 == LAST_BEAT);
                        end
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= S_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_bvalid && r_bready) begin
                        r_bready <= 1'b0;
                        if (w_last_burst) begin
                            r_state      <= S_RD;
                            r_burst_idx  <= '0;
                            r_burst_addr <= r_base;
                            r_arvalid    <= 1'b1;
                            r_araddr     <= r_base;
                        end else begin
                            r_state      <= S_WR;
                            r_burst_idx  <= r_burst_idx + 16'd1;
                            r_burst_addr <= w_next_addr;
                            r_awvalid    <= 1'b1;
                            r_awaddr     <= w_next_addr;
                            r_wvalid     <= 1'b1;
                            r_wdata      <= f_pattern(w_next_addr, r_seed);
                            r_wlast      <= (LAST_BEAT == 7'd0);
                            r_beat       <= '0;
                            r_aw_done    <= 1'b0;
                            r_w_done     <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (r_arvalid && M_AXI_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                    end
                    // The beat counter, not rlast, closes the burst so a bad rlast cannot hang us.
                    if (r_rready && M_AXI_rvalid) begin
                        if (r_beat == LAST_BEAT) begin
                            r_rready <= 1'b0;
                            if (w_last_burst) begin
                                r_state <= S_FIN;
                            end else begin
                                r_burst_idx  <= r_burst_idx + 16'd1;
                                r_burst_addr <= w_next_addr;
                                r_arvalid    <= 1'b1;
                                r_araddr     <= w_next_addr;
                            end
                        end else begin
                            r_beat <= r_beat + 7'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_count == 32'd0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if ((r_state == S_IDLE) && start) begin
                r_err_count      <= '0;
                r_first_err_addr <= '0;
            end else if (w_err_hit) begin
                if (r_err_count == 32'd0) r_first_err_addr <= w_err_addr;
                if (r_err_count != 32'hFFFF_FFFF) r_err_count <= r_err_count + 32'd1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign dbg_state      = r_state;

    assign M_AXI_awvalid  = r_awvalid;
    assign M_AXI_awaddr   = r_awaddr;
    assign M_AXI_awlen    = 8'(BURST_LEN - 1);
    assign M_AXI_awid     = AXI_ID;
    assign M_AXI_awburst  = 2'b01;
    assign M_AXI_awsize   = 3'd6;
    assign M_AXI_awcache  = 4'b0011;
    assign M_AXI_awlock   = 1'b0;
    assign M_AXI_awprot   = 3'd0;
    assign M_AXI_awqos    = 4'd0;
    assign M_AXI_awregion = 4'd0;
    assign M_AXI_wvalid   = r_wvalid;
    assign M_AXI_wdata    = r_wdata;
    assign M_AXI_wstrb    = '1;
    assign M_AXI_wlast    = r_wlast;
    assign M_AXI_bready   = r_bready;
    assign M_AXI_arvalid  = r_arvalid;
    assign M_AXI_araddr   = r_araddr;
    assign M_AXI_arlen    = 8'(BURST_LEN - 1);
    assign M_AXI_arid     = AXI_ID;
    assign M_AXI_arburst  = 2'b01;
    assign M_AXI_arsize   = 3'd6;
    assign M_AXI_arcache  = 4'b0011;
    assign M_AXI_arlock   = 1'b0;
    assign M_AXI_arprot   = 3'd0;
    assign M_AXI_arqos    = 4'd0;
    assign M_AXI_arregion = 4'd0;
    assign M_AXI_rready   = r_rready;

endmodule

// File: tb/tb_garnet_ddr_axi_tester.sv
// Bench for garnet_ddr_axi_tester: memory-backed AXI slave with fault injection, a
// flat-beat-index reference model, and one compare process.
module tb_garnet_ddr_axi_tester;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic init_calib_complete, start;
  logic [63:0] base_addr, seed;
  logic [15:0] num_bursts;
  logic busy, done, pass;
  logic [31:0] err_count;
  logic [63:0] first_err_addr;
  logic [2:0] dbg_state;
  logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, arlock, rvalid, rready, rlast;
  logic [63:0] awaddr, araddr, wstrb;
  logic [7:0] awlen, arlen;
  logic [5:0] awid, arid, bid, rid;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [511:0] wdata, rdata;

  garnet_ddr_axi_tester #(.BURST_LEN(16), .AXI_ID(6'd0)) dut (
    .clk(clk), .resetn(resetn), .init_calib_complete(init_calib_complete), .start(start),
    .base_addr(base_addr), .num_bursts(num_bursts), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .dbg_state(dbg_state),
    .M_AXI_awvalid(awvalid), .M_AXI_awready(awready), .M_AXI_awaddr(awaddr),
    .M_AXI_awlen(awlen), .M_AXI_awid(awid), .M_AXI_awburst(awburst), .M_AXI_awsize(awsize),
    .M_AXI_awcache(awcache), .M_AXI_awlock(awlock), .M_AXI_awprot(awprot),
    .M_AXI_awqos(awqos), .M_AXI_awregion(awregion),
    .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_wdata(wdata),
    .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast),
    .M_AXI_bvalid(bvalid), .M_AXI_bready(bready), .M_AXI_bid(bid), .M_AXI_bresp(bresp),
    .M_AXI_arvalid(arvalid), .M_AXI_arready(arready), .M_AXI_araddr(araddr),
    .M_AXI_arlen(arlen), .M_AXI_arid(arid), .M_AXI_arburst(arburst), .M_AXI_arsize(arsize),
    .M_AXI_arcache(arcache), .M_AXI_arlock(arlock), .M_AXI_arprot(arprot),
    .M_AXI_arqos(arqos), .M_AXI_arregion(arregion),
    .M_AXI_rvalid(rvalid), .M_AXI_rready(rready), .M_AXI_rdata(rdata),
    .M_AXI_rid(rid), .M_AXI_rresp(rresp), .M_AXI_rlast(rlast)
  );

  // configuration owned by the stimulus process
  int stall_en = 0;
  int cfg_b_err = -1, cfg_c_burst = -1, cfg_c_beat = -1, cfg_rid_burst = -1, cfg_rid_beat = -1;
  int req_id = 0, req_mode = 0, lit_err = 0;
  logic [63:0] lit_first = '0;

  // state owned by the compare process
  int n_checks = 0, n_fail = 0, ack_id = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_avail, viol, m_num, e_err;
  logic [63:0] m_base, m_seed, e_first;
  logic [511:0] exp_q[$];
  logic [63:0] s_aw_addr[$], s_ar_addr[$];
  logic [511:0] s_wd[$];
  logic [511:0] mem [logic [63:0]];
  logic pa_stall, pw_stall, par_stall;
  logic [63:0] pa_addr, par_addr;
  logic [511:0] pw_data, exp_w;

  // state owned by the slave driver
  int b_mark, r_mark, dr_idx, dr_bi, dr_be;
  logic [63:0] dr_a;
  logic [511:0] dr_d;

  function automatic logic [511:0] pattern(input logic [63:0] a, input logic [63:0] s);
    logic [511:0] p;
    for (int k = 0; k < 8; k++) p[k*64 +: 64] = (a + 64'(k * 8)) ^ s;
    return p;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process: services check requests, tracks handshakes, models the run
  always @(posedge clk) begin
    if (req_id != ack_id) begin
      case (req_mode)
        1: begin
          check("done", done, 1'b1);
          check("busy_end", busy, 1'b0);
          check("pass", pass, (e_err == 0));
          check("err_count", err_count, 32'(e_err));
          check("first_err_addr", first_err_addr, e_first);
          check("model_err_pin", 32'(e_err), 32'(lit_err));
          check("model_first_pin", e_first, lit_first);
          check("aw_count", aw_cnt, m_num);
          check("w_count", w_cnt, m_num * 16);
          check("ar_count", ar_cnt, m_num);
          check("r_count", r_cnt, m_num * 16);
          check("traffic_before_cal", viol, 0);
          check("idle_bus", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
          check("aw_consts", {awburst, awsize, awcache, awlock, awprot, awqos, awregion},
                {2'b01, 3'd6, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0});
          check("ar_consts", {arburst, arsize, arcache, arlock, arprot, arqos, arregion},
                {2'b01, 3'd6, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0});
        end
        2: begin
          check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
          check("rst_busy", busy, 1'b0);
        end
        default: begin
          check("idle_status", {busy, done, pass}, 3'b000);
          check("idle_err_count", err_count, 32'd0);
          check("idle_first_err", first_err_addr, 64'd0);
          check("idle_bus", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        end
      endcase
      ack_id = req_id;
    end

    if (!resetn) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_avail = 0;
      s_aw_addr.delete(); s_wd.delete(); s_ar_addr.delete(); exp_q.delete();
      pa_stall = 0; pw_stall = 0; par_stall = 0;
    end else if (start && !busy) begin
      m_base = base_addr; m_seed = seed; m_num = int'(num_bursts);
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_avail = 0; viol = 0;
      s_aw_addr.delete(); s_wd.delete(); s_ar_addr.delete(); exp_q.delete();
      pa_stall = 0; pw_stall = 0; par_stall = 0;
      for (int i = 0; i < m_num * 16; i++) exp_q.push_back(pattern(m_base + 64'(i) * 64, m_seed));
      e_err = 0; e_first = '0;
      if (cfg_b_err >= 0 && cfg_b_err < m_num) begin
        e_err++; e_first = m_base + 64'(cfg_b_err) * 1024;
      end
      for (int b = 0; b < m_num; b++)
        for (int be = 0; be < 16; be++)
          if ((b == cfg_c_burst && be == cfg_c_beat) || (b == cfg_rid_burst && be == cfg_rid_beat)) begin
            if (e_err == 0) e_first = m_base + 64'(b) * 1024 + 64'(be) * 64;
            e_err++;
          end
    end else begin
      if (pa_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, pa_addr});
      if (pw_stall) check("w_hold", {wvalid, wdata}, {1'b1, pw_data});
      if (par_stall) check("ar_hold", {arvalid, araddr}, {1'b1, par_addr});
      if (!init_calib_complete && (awvalid || wvalid || arvalid)) viol++;
      if (awvalid && awready) begin
        check("awaddr", awaddr, m_base + 64'(aw_cnt) * 1024);
        check("awlen_id", {awlen, awid}, {8'd15, 6'd0});
        s_aw_addr.push_back(awaddr);
        aw_cnt++;
      end
      if (wvalid && wready) begin
        exp_w = '0;
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        check("wdata", wdata, exp_w);
        check("wlast_wstrb", {wlast, wstrb}, {(w_cnt % 16 == 15), 64'hFFFF_FFFF_FFFF_FFFF});
        if (w_cnt == 0 && m_seed == 64'd0 && m_base == 64'h1000)
          check("w0_lane1", wdata[127:64], 64'h1008);
        s_wd.push_back(wdata);
        w_cnt++;
      end
      while (b_avail < s_aw_addr.size() && s_wd.size() >= (b_avail + 1) * 16) begin
        for (int i = 0; i < 16; i++) mem[s_aw_addr[b_avail] + 64'(i) * 64] = s_wd[b_avail * 16 + i];
        b_avail++;
      end
      if (bvalid && bready) b_cnt++;
      if (arvalid && arready) begin
        check("araddr", araddr, m_base + 64'(ar_cnt) * 1024);
        check("arlen_id", {arlen, arid}, {8'd15, 6'd0});
        s_ar_addr.push_back(araddr);
        ar_cnt++;
      end
      if (rvalid && rready) r_cnt++;
      pa_stall = awvalid && !awready;  pa_addr = awaddr;
      pw_stall = wvalid && !wready;    pw_data = wdata;
      par_stall = arvalid && !arready; par_addr = araddr;
    end
  end

  // slave driver: readies, B and R channels, with fault injection
  always @(negedge clk) begin
    if (!resetn) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      bresp = 0; bid = 0; rresp = 0; rid = 0; rdata = '0;
    end else begin
      awready = (stall_en == 0) || ($urandom_range(0, 3) == 0);
      wready = (stall_en == 0) || ($urandom_range(0, 1) == 0);
      arready = (stall_en == 0) || ($urandom_range(0, 2) == 0);
      if (!(bvalid && b_cnt == b_mark)) begin
        bvalid = 0;
        if (b_avail > b_cnt && ((stall_en == 0) || ($urandom_range(0, 1) == 0))) begin
          bvalid = 1; b_mark = b_cnt; bid = 6'd0;
          bresp = (b_cnt == cfg_b_err) ? 2'b10 : 2'b00;
        end
      end
      if (!(rvalid && r_cnt == r_mark)) begin
        rvalid = 0; rlast = 0;
        if (ar_cnt * 16 > r_cnt && ((stall_en == 0) || ($urandom_range(0, 2) != 0))) begin
          dr_idx = r_cnt; dr_bi = dr_idx / 16; dr_be = dr_idx % 16;
          dr_a = s_ar_addr[dr_bi] + 64'(dr_be) * 64;
          dr_d = mem.exists(dr_a) ? mem[dr_a] : '0;
          if (dr_bi == cfg_c_burst && dr_be == cfg_c_beat) dr_d[63:0] = dr_d[63:0] ^ 64'hFF;
          rdata = dr_d;
          rid = (dr_bi == cfg_rid_burst && dr_be == cfg_rid_beat) ? 6'h15 : 6'd0;
          rresp = 2'b00; rlast = (dr_be == 15); rvalid = 1; r_mark = r_cnt;
        end
      end
    end
  end

  // driver tasks
  task automatic do_req(input int mode);
    req_mode = mode;
    req_id++;
    for (int i = 0; i < 10 && ack_id != req_id; i++) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [63:0] b, input logic [15:0] n, input logic [63:0] s);
    @(negedge clk);
    base_addr = b; num_bursts = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done && !busy) break;
      @(negedge clk);
    end
  endtask

  task automatic set_faults(input int b_err, input int c_bu, input int c_be, input int r_bu, input int r_be);
    cfg_b_err = b_err; cfg_c_burst = c_bu; cfg_c_beat = c_be; cfg_rid_burst = r_bu; cfg_rid_beat = r_be;
  endtask

  initial begin
    resetn = 0; init_calib_complete = 1; start = 0;
    base_addr = '0; num_bursts = '0; seed = '0;
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    do_req(3);

    // ideal slave, seed 0
    set_faults(-1, -1, -1, -1, -1);
    start_pulse(64'h1000, 16'd4, 64'd0);
    wait_done(5000);
    lit_err = 0; lit_first = 64'd0;
    do_req(1);

    // corrupted read data, burst 2 beat 5
    set_faults(-1, 2, 5, -1, -1);
    start_pulse(64'h1000, 16'd4, 64'hA5A5_A5A5_A5A5_A5A5);
    wait_done(5000);
    lit_err = 1; lit_first = 64'h1940;
    do_req(1);

    // SLVERR on burst 1 and a wrong rid in burst 3
    set_faults(1, -1, -1, 3, 7);
    start_pulse(64'h1000, 16'd4, 64'h0123_4567_89AB_CDEF);
    wait_done(5000);
    lit_err = 2; lit_first = 64'h1400;
    do_req(1);

    // late calibration with random stalls
    set_faults(-1, -1, -1, -1, -1);
    stall_en = 1; init_calib_complete = 0;
    start_pulse(64'h8_0000_0000, 16'd4, 64'hDEAD_BEEF_0000_1111);
    repeat (100) @(negedge clk);
    init_calib_complete = 1;
    wait_done(20000);
    lit_err = 0; lit_first = 64'd0;
    do_req(1);
    stall_en = 0;

    // zero bursts; a second start while busy must be ignored
    init_calib_complete = 0;
    start_pulse(64'h2000, 16'd0, 64'd7);
    repeat (5) @(negedge clk);
    start_pulse(64'h3000, 16'd4, 64'd9);
    repeat (5) @(negedge clk);
    init_calib_complete = 1;
    wait_done(5000);
    do_req(1);

    // reset in the middle of a W burst, then a clean run
    start_pulse(64'h1000, 16'd4, 64'd0);
    for (int i = 0; i < 500; i++) begin
      if (wvalid && w_cnt >= 3) break;
      @(negedge clk);
    end
    #2 resetn = 0;
    do_req(2);
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    do_req(3);
    start_pulse(64'h1000, 16'd4, 64'd0);
    wait_done(5000);
    do_req(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
